// File: rtl/zbt_point_write_seq.sv
// Walks a table of packed (x, y, color) point words and writes each in-range
// point's colour into ZBT frame memory, arbitrating via a per-cycle req/grant.
module zbt_point_write_seq #(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_WIDTH   = 3,
  parameter int ADDR_WIDTH  = 19,
  parameter int H_PIXELS    = 640,
  parameter int V_PIXELS    = 480,
  parameter int BASE_ADDR   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic [IDX_WIDTH-1:0]  index,
  input  logic [35:0]           value,
  output logic                  zbt_req,
  input  logic                  zbt_grant,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [35:0]           mem_data,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_WIDTH:0]    write_count,
  output logic [IDX_WIDTH:0]    skip_count
);

  localparam int CNT_W  = IDX_WIDTH + 1;
  localparam int FULL_W = 32;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   index_q, index_d;
  logic [9:0]             x_q, x_d;
  logic [9:0]             y_q, y_d;
  logic [9:0]             color_q, color_d;
  logic                   req_q, req_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [9:0]             wcolor_q, wcolor_d;
  logic [CNT_W-1:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0]       scnt_q, scnt_d;

  logic [FULL_W-1:0]      addr_full;
  logic                   out_of_range;
  logic                   last_entry;
  logic                   value_pad_unused;
  logic                   addr_hi_unused;

  // Pixel address is formed at 32 bits and only then cut to the bus width.
  assign addr_full    = FULL_W'(BASE_ADDR)
                      + FULL_W'(y_q) * FULL_W'(H_PIXELS)
                      + FULL_W'(x_q);
  assign out_of_range = (FULL_W'(x_q) >= FULL_W'(H_PIXELS)) ||
                        (FULL_W'(y_q) >= FULL_W'(V_PIXELS));
  assign last_entry   = (index_q == LAST_IDX);

  assign value_pad_unused = ^value[35:30];
  assign addr_hi_unused   = ^addr_full[FULL_W-1:ADDR_WIDTH];

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    req_d    = req_q;
    addr_d   = addr_q;
    wcolor_d = wcolor_q;
    wcnt_d   = wcnt_q;
    scnt_d   = scnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wcnt_d  = '0;
          scnt_d  = '0;
          index_d = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        x_d     = value[29:20];
        y_d     = value[19:10];
        color_d = value[9:0];
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if (out_of_range) begin
          scnt_d = scnt_q + CNT_W'(1);
          if (last_entry) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + IDX_WIDTH'(1);
            state_d = S_LOAD;
          end
        end else begin
          addr_d   = addr_full[ADDR_WIDTH-1:0];
          wcolor_d = color_q;
          req_d    = 1'b1;
          state_d  = S_WRITE;
        end
      end

      // Request, address and data stay put until the arbiter grants.
      S_WRITE: begin
        if (zbt_grant) begin
          req_d  = 1'b0;
          wcnt_d = wcnt_q + CNT_W'(1);
          if (last_entry) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + IDX_WIDTH'(1);
            state_d = S_LOAD;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      index_q  <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      wcolor_q <= '0;
      wcnt_q   <= '0;
      scnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      wcolor_q <= wcolor_d;
      wcnt_q   <= wcnt_d;
      scnt_q   <= scnt_d;
    end
  end

  // Point fields are reloaded in LOAD before every use, so they need no reset.
  always_ff @(posedge clk) begin
    x_q     <= x_d;
    y_q     <= y_d;
    color_q <= color_d;
  end

  assign index       = index_q;
  assign zbt_req     = req_q;
  assign mem_addr    = addr_q;
  assign mem_data    = {26'b0, wcolor_q};
  assign mem_we      = req_q & zbt_grant;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign write_count = wcnt_q;
  assign skip_count  = scnt_q;

endmodule

// File: tb/tb_zbt_point_write_seq.sv
// Scoreboard bench for zbt_point_write_seq: expected writes are derived from
// the point table and the documented cycle timing, then matched against mem_we.
module tb_zbt_point_write_seq;

  localparam int NUM_ENTRIES = 8;
  localparam int IDX_WIDTH   = 3;
  localparam int ADDR_WIDTH  = 19;
  localparam int H_PIXELS    = 640;
  localparam int V_PIXELS    = 480;
  localparam int BASE_ADDR   = 0;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  start;
  logic [IDX_WIDTH-1:0]  index;
  logic [35:0]           value;
  logic                  zbt_req;
  logic                  zbt_grant;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [35:0]           mem_data;
  logic                  mem_we;
  logic                  busy;
  logic                  done;
  logic [IDX_WIDTH:0]    write_count;
  logic [IDX_WIDTH:0]    skip_count;

  logic [35:0] tbl [NUM_ENTRIES];
  assign value = tbl[index];

  typedef struct {
    int                    cyc;
    logic [ADDR_WIDTH-1:0] addr;
    logic [35:0]           data;
  } wr_t;

  wr_t exp_q[$];
  int  exp_done;
  int  exp_w;
  int  exp_s;
  int  checks = 0;
  int  passed = 0;

  zbt_point_write_seq #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .IDX_WIDTH  (IDX_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .H_PIXELS   (H_PIXELS),
    .V_PIXELS   (V_PIXELS),
    .BASE_ADDR  (BASE_ADDR)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .index      (index),
    .value      (value),
    .zbt_req    (zbt_req),
    .zbt_grant  (zbt_grant),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .busy       (busy),
    .done       (done),
    .write_count(write_count),
    .skip_count (skip_count)
  );

  always #5 clk = ~clk;

  task automatic set_entry(input int i, input int x, input int y, input int c);
    tbl[i] = {6'b0, 10'(x), 10'(y), 10'(c)};
  endtask

  task automatic load_plan_table();
    set_entry(0, 100, 100, 'h3FC);
    set_entry(1, 100, 100, 'h0FC);
    set_entry(2, 200, 200, 'h3FC);
    set_entry(3, 300, 300, 'h0FC);
    set_entry(4, 400, 400, 'h3FC);
    set_entry(5, 500, 500, 'h0FC);
    set_entry(6, 100, 100, 'h3FC);
    set_entry(7, 200, 200, 'h0FC);
  endtask

  // Timing model: skipped entry = 2 cycles, written entry = 3 + grant delay.
  task automatic build_expect(input int delay);
    int t;
    int x;
    int y;
    int c;
    wr_t e;
    exp_q.delete();
    t = 0;
    exp_w = 0;
    exp_s = 0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      x = int'(tbl[i][29:20]);
      y = int'(tbl[i][19:10]);
      c = int'(tbl[i][9:0]);
      if (x >= H_PIXELS || y >= V_PIXELS) begin
        t += 2;
        exp_s++;
      end else begin
        t += 3 + delay;
        e.cyc  = t;
        e.addr = ADDR_WIDTH'(BASE_ADDR + y * H_PIXELS + x);
        e.data = {26'b0, 10'(c)};
        exp_q.push_back(e);
        exp_w++;
      end
    end
    exp_done = t + 1;
  endtask

  task automatic run_pass(input int delay, input bit spam, input string tag);
    int  c;
    int  held;
    bit  seen_done;
    bit  hold_valid;
    wr_t e;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [35:0]           hold_data;
    build_expect(delay);
    @(negedge clk);
    start     = 1'b1;
    zbt_grant = (delay == 0);
    @(posedge clk);
    #1 start = 1'b0;
    c = 0;
    held = 0;
    seen_done = 1'b0;
    hold_valid = 1'b0;
    while (c < 300 && !seen_done) begin
      @(negedge clk);
      if (spam) start = (c % 2 == 1);
      if (delay > 0) begin
        if (zbt_req) begin
          zbt_grant = (held >= delay);
          held++;
        end else begin
          zbt_grant = 1'b0;
          held = 0;
        end
      end
      #1;
      if (c == 0) begin
        checks++;
        if (busy !== 1'b1 || write_count !== '0 || skip_count !== '0) begin
          $display("FAIL %s pass_start: busy=%b wc=%0d sc=%0d, required busy=1 wc=0 sc=0",
                   tag, busy, write_count, skip_count);
        end else passed++;
      end
      if (zbt_req && hold_valid) begin
        checks++;
        if (mem_addr !== hold_addr || mem_data !== hold_data) begin
          $display("FAIL %s hold_stable: addr=%0d data=%h, required addr=%0d data=%h",
                   tag, mem_addr, mem_data, hold_addr, hold_data);
        end else passed++;
      end
      hold_valid = zbt_req && !mem_we;
      hold_addr  = mem_addr;
      hold_data  = mem_data;
      if (!zbt_grant) begin
        checks++;
        if (mem_we !== 1'b0) begin
          $display("FAIL %s we_without_grant: mem_we=%b, required 0", tag, mem_we);
        end else passed++;
      end
      if (mem_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s unexpected_write: cycle=%0d addr=%0d, required no write",
                   tag, c + 1, mem_addr);
        end else begin
          e = exp_q.pop_front();
          if (c + 1 !== e.cyc || mem_addr !== e.addr || mem_data !== e.data) begin
            $display("FAIL %s write: cycle=%0d addr=%0d data=%h, required cycle=%0d addr=%0d data=%h",
                     tag, c + 1, mem_addr, mem_data, e.cyc, e.addr, e.data);
          end else passed++;
        end
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        checks++;
        if (c + 1 !== exp_done || write_count !== (IDX_WIDTH+1)'(exp_w) ||
            skip_count !== (IDX_WIDTH+1)'(exp_s) || index !== IDX_WIDTH'(NUM_ENTRIES - 1)) begin
          $display("FAIL %s done: cycle=%0d wc=%0d sc=%0d idx=%0d, required cycle=%0d wc=%0d sc=%0d idx=%0d",
                   tag, c + 1, write_count, skip_count, index, exp_done, exp_w, exp_s,
                   NUM_ENTRIES - 1);
        end else passed++;
      end
      if (!seen_done) begin
        @(posedge clk);
        c++;
      end
    end
    if (!seen_done) begin
      checks++;
      $display("FAIL %s timeout: no done after %0d cycles, required done at %0d", tag, c, exp_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s missing_writes: %0d outstanding, required 0", tag, exp_q.size());
    end else passed++;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    start     = 1'b0;
    zbt_grant = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({index, zbt_req, mem_addr, mem_data, mem_we} !== '0) begin
      $display("FAIL reset_datapath: idx=%0d req=%b addr=%0d data=%h we=%b, required all 0",
               index, zbt_req, mem_addr, mem_data, mem_we);
    end else passed++;
    checks++;
    if ({busy, done, write_count, skip_count} !== '0) begin
      $display("FAIL reset_status: busy=%b done=%b wc=%0d sc=%0d, required all 0",
               busy, done, write_count, skip_count);
    end else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || zbt_req !== 1'b0) begin
      $display("FAIL idle_without_start: busy=%b req=%b, required 0 0", busy, zbt_req);
    end else passed++;
  endtask

  task automatic test_basic();
    load_plan_table();
    run_pass(0, 1'b0, "basic");
  endtask

  task automatic test_grant_stall();
    load_plan_table();
    run_pass(5, 1'b0, "stall");
  endtask

  task automatic test_back_to_back();
    load_plan_table();
    run_pass(0, 1'b1, "start_spam");
    run_pass(0, 1'b0, "back_to_back");
  endtask

  task automatic test_reset_mid_write();
    int n;
    load_plan_table();
    @(negedge clk);
    start     = 1'b1;
    zbt_grant = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (write_count !== 4'd2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    zbt_grant = 1'b0;
    n = 0;
    while (zbt_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (zbt_req !== 1'b1 || write_count !== 4'd2) begin
      $display("FAIL rst_mid_setup: req=%b wc=%0d, required req=1 wc=2", zbt_req, write_count);
    end else passed++;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    zbt_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (mem_we !== 1'b0 || busy !== 1'b0 || zbt_req !== 1'b0 ||
          write_count !== '0 || skip_count !== '0) begin
        $display("FAIL rst_mid_write[%0d]: we=%b busy=%b req=%b wc=%0d sc=%0d, required all 0",
                 k, mem_we, busy, zbt_req, write_count, skip_count);
      end else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_edge_points();
    set_entry(0, 639, 479, 'h3FF);
    set_entry(1, 640,   0, 'h001);
    set_entry(2,   0, 480, 'h002);
    set_entry(3,   0,   0, 'h155);
    set_entry(4, 1023, 1023, 'h0AA);
    set_entry(5, 638, 478, 'h2AA);
    set_entry(6, 320, 240, 'h123);
    set_entry(7,   0,   1, 'h321);
    run_pass(0, 1'b0, "edge");
    set_entry(0, 639, 479, 'h3FF);
    build_expect(0);
    checks++;
    if (exp_q[0].addr !== 19'd307199) begin
      $display("FAIL edge_model_addr: addr=%0d, required 307199", exp_q[0].addr);
    end else passed++;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_grant_stall();
    test_back_to_back();
    test_reset_mid_write();
    test_edge_points();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/zbt_point_write_seq.md
Name: zbt_point_write_seq

Overview:
- Sequencer that walks a table of NUM_ENTRIES 36-bit point words, each {6'b0, x[9:0], y[9:0], color[9:0]}, and writes each point's colour into ZBT frame memory at the pixel address for (x, y).
- Shares the ZBT write port with other clients through a per-cycle req/grant handshake to the memory arbiter.
- Sits between the point-table source and the ZBT write arbiter. Used for bring-up and manual loading of test scans.

Parameters:
- NUM_ENTRIES, 8: number of table entries walked; must be ≥1 and ≤ 2^IDX_WIDTH.
- IDX_WIDTH, 3: width of the table index.
- ADDR_WIDTH, 19: ZBT address width.
- H_PIXELS, 640: frame width; also the row stride.
- V_PIXELS, 480: frame height.
- BASE_ADDR, 0: ZBT address of pixel (0,0).

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: synchronous active-low reset.
- start, in, 1: begin one pass over the table. Sampled only in IDLE.
- index, out, IDX_WIDTH: table index driven to the point-table source.
- value, in, 36: table word for index; combinational from index.
- zbt_req, out, 1: write request to the arbiter.
- zbt_grant, in, 1: arbiter grant, valid in the same cycle.
- mem_addr, out, ADDR_WIDTH: ZBT write address.
- mem_data, out, 36: ZBT write data, equal to {26'b0, color}.
- mem_we, out, 1: write strobe, equal to zbt_req & zbt_grant.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse at the end of a pass.
- write_count, out, IDX_WIDTH+1: writes issued in the current or last pass.
- skip_count, out, IDX_WIDTH+1: out-of-range points skipped.

Behaviour:
- Reset (reset_n=0 at a clk edge), regardless of state:
  - state=IDLE.
  - index, zbt_req, mem_addr, mem_data, busy, done, write_count and skip_count are all 0.
  - mem_we is therefore 0.
  - Reset mid-pass abandons the pass. No write occurs in the cycle after reset.
- States: IDLE, LOAD, CHECK, WRITE, DONE.
- IDLE:
  - On start=1, clear both counters, set index=0, go to LOAD.
  - start is ignored in every other state.
- LOAD (1 cycle): value for the current index is stable; register x, y, color.
- CHECK (1 cycle):
  - If x ≥ H_PIXELS or y ≥ V_PIXELS: skip_count+1, then advance.
  - Otherwise: register mem_addr = BASE_ADDR + y*H_PIXELS + x, computed at full width and then truncated to ADDR_WIDTH.
  - Also register mem_data = {26'b0, color} and set zbt_req=1. Go to WRITE.
- WRITE:
  - zbt_req, mem_addr and mem_data are held stable until grant.
  - In the first cycle with zbt_grant=1: mem_we=1 (exactly one write per entry), write_count+1, zbt_req drops at the next edge, then advance.
  - Grant may be withheld for any number of cycles; the state waits indefinitely.
  - zbt_grant while zbt_req=0 has no effect.
- Advance:
  - If index == NUM_ENTRIES-1, go to DONE.
  - Otherwise index+1 and go to LOAD.
  - index never wraps within a pass.
- DONE (1 cycle): done=1, then IDLE.
  - index holds the last value.
  - Counters hold until the next start.
- Latency with zbt_grant tied high and start accepted at edge 0:
  - Entry k is written in cycle 3+3k when no entries are skipped.
  - A skipped entry costs 2 cycles (LOAD, CHECK) and no write.
  - All-in-range pass: done in cycle 3·NUM_ENTRIES+1.
- Invariant: write_count + skip_count == NUM_ENTRIES at done.

Test Plan:
- Reset, then start at cycle 0, grant tied 1. Table: (100,100,0x3FC), (100,100,0x0FC), (200,200,0x3FC), (300,300,0x0FC), (400,400,0x3FC), (500,500,0x0FC), (100,100,0x3FC), (200,200,0x0FC). Required response:
  - Writes at cycles 3,6,9,12,15,20,23 with addr 64100, 64100, 128200, 192300, 256400, 64100, 128200.
  - Data 0x3FC/0x0FC alternating as in the table.
  - Entry 5 skipped (y=500 ≥ 480).
  - done at cycle 24; write_count=7, skip_count=1.
- Same table, grant held low for 5 cycles each time req rises:
  - mem_addr and mem_data stay stable while req=1.
  - mem_we never asserts without grant.
  - Exactly 7 writes; done at cycle 59.
- start pulsed repeatedly while busy: no restart, counters unaffected. A start in the cycle after done begins a new pass with counters cleared.
- reset_n=0 while in WRITE with grant low, then grant=1 after reset: mem_we stays 0, busy=0, counters=0.
- Edge point (639,479,0x3FF) written at addr 307199. Points (640,0) and (0,480) are both skipped.
